flag_reg_dec_unit: RTL and testbench
====================================

FLAG_REG_DEC_UNIT -- requirements
Module: flag_reg_dec

Interface
- REQ-001 SHALL have parameter FR_FLAG_W, default 4: flag register width, bit order {V,S,C,Z} = [3:0].
- REQ-002 SHALL have parameter FR_FUNC_W, default 4: branch-condition selector width.
- REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port n_rst, input, 1: reset, synchronous and active-high; the port keeps the codebase name despite its high polarity.
- REQ-005 SHALL have port flags, input, FR_FLAG_W: ALU flags, [0]=Z zero, [1]=C carry, [2]=S sign, [3]=V overflow.
- REQ-006 SHALL have port func, input, FR_FUNC_W: branch condition code.
- REQ-007 SHALL have port bre, input, 1: branch enable; high marks the current instruction as a conditional branch.
- REQ-008 SHALL have port is_br, output, 1: branch taken.

Function
- REQ-009 SHALL hold an internal FR_FLAG_W-bit flag register flag_q.
- REQ-010 SHALL load flag_q <= flags on a rising edge when n_rst=0 and bre=0, so non-branch instructions update the flags.
- REQ-011 SHALL keep flag_q unchanged on a rising edge when n_rst=0 and bre=1, so branches never modify the flags.
- REQ-012 SHALL drive is_br combinationally: is_br = bre AND cond(func, flag_q) when n_rst=0. The input flags never feed is_br directly.
- REQ-013 SHALL decode func into cond as follows. Unsigned/simple codes:
  - 0 never = 0
  - 1 always = 1
  - 2 EQ = Z
  - 3 NE = !Z
  - 4 CS = C
  - 5 CC = !C
  - 6 MI = S
  - 7 PL = !S
  - 8 VS = V
  - 9 VC = !V
  - 10 HI = C & !Z
  - 11 LS = !C | Z
- REQ-014 SHALL decode the signed codes as follows:
  - 12 GE = (S==V)
  - 13 LT = (S!=V)
  - 14 GT = !Z & (S==V)
  - 15 LE = Z | (S!=V)
- REQ-015 SHALL make a flag update visible on is_br from the edge that loads it. Latency from flags to is_br is one clock; from func/bre to is_br it is zero.
- REQ-016 SHALL drive is_br=0 whenever bre=0, regardless of func and flag_q.
- REQ-017 SHALL produce no X on is_br for any func/flag_q combination once reset has been applied.

Reset
- REQ-018 SHALL clear flag_q to 0 on a rising edge with n_rst=1; reset dominates bre.
- REQ-019 SHALL force is_br=0 combinationally while n_rst=1.
- REQ-020 SHALL have flag_q=0 after release, so is_br equals cond(func, 0000) & bre (e.g. NE → 1, EQ → 0) until the first load.

Configuration
- REQ-021 SHALL support macro FR_SIGNED_COND_EN.
  - Defined: codes 12–15 decode per REQ-014.
  - Undefined: codes 12–15 yield cond=0. The V flag is still stored, and codes 8/9 are unaffected.

Verification
- REQ-022 SHALL verify reset: n_rst=1 for 1 edge with flags=4'hF, bre=0 → flag_q=0, is_br=0; release with bre=1, func=3 → is_br=1.
- REQ-023 SHALL verify load: bre=0, flags=4'b0001, one edge → then bre=1, func=2 → is_br=1; func=3 → is_br=0.
- REQ-024 SHALL verify hold: flag_q=4'b0001, bre=1, flags=4'b0000 for 3 edges → func=2 still gives is_br=1.
- REQ-025 SHALL verify exhaustive decode: for all 16 func × 16 flag values loaded with bre=0, then bre=1 → is_br matches REQ-013/014; with bre=0 → is_br=0 throughout.
- REQ-026 SHALL verify signed: flag_q=4'b1000 (V=1, S=0), func=13 → is_br=1 with FR_SIGNED_COND_EN defined, 0 without.
- REQ-027 SHALL verify reset mid-sequence: flag_q=4'hF, n_rst=1 with bre=1, func=1 → is_br=0 while asserted; after one edge flag_q=0.

Source files
------------

// File: rtl/flag_reg_dec_unit_if.sv
// Branch-decode bus: ALU flags, condition code and branch enable in, branch-taken out.
interface flag_reg_dec_unit_if #(
  parameter int unsigned FR_FLAG_W = 4,
  parameter int unsigned FR_FUNC_W = 4
);
  logic [FR_FLAG_W-1:0] flags;
  logic [FR_FUNC_W-1:0] func;
  logic                 bre;
  logic                 is_br;

  modport master (output flags, output func, output bre, input is_br);
  modport slave  (input flags, input func, input bre, output is_br);
endinterface

// File: rtl/flag_reg_dec_unit.sv
// Flag register plus branch-condition decoder; n_rst is an active-high synchronous reset.
// Signed conditions (codes 12-15) are enabled by defining FR_SIGNED_COND_EN.
module flag_reg_dec_unit #(
  parameter int unsigned FR_FLAG_W = 4,
  parameter int unsigned FR_FUNC_W = 4
) (
  input  logic                  clock,
  input  logic                  n_rst,
  flag_reg_dec_unit_if.slave    bus
);

  localparam int unsigned Z_BIT = 0;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned S_BIT = 2;
  localparam int unsigned V_BIT = 3;

  logic [FR_FLAG_W-1:0] flag_q;
  logic                 z_f;
  logic                 c_f;
  logic                 s_f;
  logic                 v_f;
  logic                 cond;

  // Branches never touch the flags; everything else reloads them.
  always_ff @(posedge clock) begin
    if (n_rst) begin
      flag_q <= '0;
    end else if (!bus.bre) begin
      flag_q <= bus.flags;
    end
  end

  assign z_f = flag_q[Z_BIT];
  assign c_f = flag_q[C_BIT];
  assign s_f = flag_q[S_BIT];
  assign v_f = flag_q[V_BIT];

  always_comb begin
    cond = 1'b0;
    case (bus.func)
      FR_FUNC_W'(0):  cond = 1'b0;
      FR_FUNC_W'(1):  cond = 1'b1;
      FR_FUNC_W'(2):  cond = z_f;
      FR_FUNC_W'(3):  cond = ~z_f;
      FR_FUNC_W'(4):  cond = c_f;
      FR_FUNC_W'(5):  cond = ~c_f;
      FR_FUNC_W'(6):  cond = s_f;
      FR_FUNC_W'(7):  cond = ~s_f;
      FR_FUNC_W'(8):  cond = v_f;
      FR_FUNC_W'(9):  cond = ~v_f;
      FR_FUNC_W'(10): cond = c_f & ~z_f;
      FR_FUNC_W'(11): cond = ~c_f | z_f;
`ifdef FR_SIGNED_COND_EN
      FR_FUNC_W'(12): cond = ~(s_f ^ v_f);
      FR_FUNC_W'(13): cond = s_f ^ v_f;
      FR_FUNC_W'(14): cond = ~z_f & ~(s_f ^ v_f);
      FR_FUNC_W'(15): cond = z_f | (s_f ^ v_f);
`endif
      default:        cond = 1'b0;
    endcase
  end

  // Combinational by design: func/bre reach is_br with zero latency.
  assign bus.is_br = ~n_rst & bus.bre & cond;

endmodule

// File: tb/tb_flag_reg_dec_unit.sv
// Scoreboard bench for flag_reg_dec_unit: directed scenarios, exhaustive decode sweep, random traffic.
module tb_flag_reg_dec_unit;

  logic clock;
  logic n_rst;

  flag_reg_dec_unit_if #(.FR_FLAG_W(4), .FR_FUNC_W(4)) bus ();

  flag_reg_dec_unit #(.FR_FLAG_W(4), .FR_FUNC_W(4)) u_dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit    exp;
    string name;
  } sb_t;

  sb_t        sb_q[$];
  logic [3:0] model_q;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference: branch conditions written straight from the flag meanings.
  function automatic bit ref_cond(input logic [3:0] fn, input logic [3:0] q);
    bit z, c, s, v;
    bit t[16];
    bit signed_en;
    z = q[0]; c = q[1]; s = q[2]; v = q[3];
`ifdef FR_SIGNED_COND_EN
    signed_en = 1'b1;
`else
    signed_en = 1'b0;
`endif
    t = '{1'b0, 1'b1, z, !z, c, !c, s, !s, v, !v,
          c && !z, !c || z, s == v, s != v, !z && (s == v), z || (s != v)};
    if (fn >= 4'd12 && !signed_en) return 1'b0;
    return t[fn];
  endfunction

  // One cycle of stimulus: expectation for this cycle goes to the scoreboard, model updates at the edge.
  task automatic drive(input bit rst, input bit b, input logic [3:0] fn,
                       input logic [3:0] fl, input string nm);
    sb_t e;
    n_rst     = rst;
    bus.bre   = b;
    bus.func  = fn;
    bus.flags = fl;
    e.exp  = rst ? 1'b0 : (b & ref_cond(fn, model_q));
    e.name = nm;
    sb_q.push_back(e);
    @(posedge clock);
    if (rst) model_q = 4'h0;
    else if (!b) model_q = fl;
    #1;
  endtask

  // Monitor: is_br is always presented; compare mid-cycle against the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus.is_br !== e.exp) begin
          n_fail++;
          $display("FAIL %s: is_br got %b expected %b (t=%0t)", e.name, bus.is_br, e.exp, $time);
        end
      end
    end
  end

  initial begin
    n_rst     = 1'b1;
    bus.bre   = 1'b0;
    bus.func  = 4'h0;
    bus.flags = 4'h0;
    model_q   = 4'hx;
    @(posedge clock);
    #1;

    // Reset, then NE on cleared flags
    drive(1'b1, 1'b0, 4'd0, 4'hF, "reset_hold");
    drive(1'b0, 1'b1, 4'd3, 4'h0, "reset_release_ne");
    drive(1'b0, 1'b1, 4'd2, 4'h0, "reset_release_eq");

    // Load Z, then EQ/NE
    drive(1'b0, 1'b0, 4'd2, 4'b0001, "load_bre0");
    drive(1'b0, 1'b1, 4'd2, 4'b0000, "load_eq");
    drive(1'b0, 1'b1, 4'd3, 4'b0000, "load_ne");

    // Hold across branches
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'd2, 4'b0000, "hold_eq");

    // Exhaustive decode sweep
    for (int f = 0; f < 16; f++) begin
      for (int fn = 0; fn < 16; fn++) begin
        drive(1'b0, 1'b0, 4'(fn), 4'(f), "sweep_bre0");
        drive(1'b0, 1'b1, 4'(fn), 4'($urandom_range(0, 15)), "sweep_decode");
      end
    end

    // Signed LT with V=1, S=0
    drive(1'b0, 1'b0, 4'd13, 4'b1000, "signed_load");
    drive(1'b0, 1'b1, 4'd13, 4'b0000, "signed_lt");
    drive(1'b0, 1'b1, 4'd8, 4'b0000, "signed_vs");

    // Reset mid-sequence dominates bre
    drive(1'b0, 1'b0, 4'd1, 4'hF, "midrst_load");
    drive(1'b0, 1'b1, 4'd4, 4'h0, "midrst_cs_before");
    drive(1'b1, 1'b1, 4'd1, 4'h0, "midrst_asserted");
    drive(1'b0, 1'b1, 4'd1, 4'h0, "midrst_always");
    drive(1'b0, 1'b1, 4'd4, 4'h0, "midrst_cs_cleared");
    drive(1'b0, 1'b1, 4'd3, 4'h0, "midrst_ne_cleared");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
    end

    bus.bre = 1'b0;
    repeat (2) @(posedge clock);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
